// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment display sharing one nibble-to-segment encoder. Keeps a
// tear-free shadow of the displayed value, walks the digits with a blank
// guard interval at the start of each slot, and can hide leading zeros.
module fnd_scan_ctrl #(
  parameter int NUM_DIG   = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [4*NUM_DIG-1:0]   value,
  input  logic                   load,
  input  logic                   lz_en,
  output logic [3:0]             enc_din,
  output logic [NUM_DIG-1:0]     dig_sel,
  output logic                   frame_done,
  output logic                   upd_pending
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIG-1:0] pend_q, pend_d;
  logic                 upd_pending_q, upd_pending_d;
  logic [3:0]           enc_din_q, enc_din_d;
  logic [NUM_DIG-1:0]   dig_sel_q, dig_sel_d;
  logic                 frame_done_q, frame_done_d;
  logic                 apply_shadow;

  // Scan sequencing plus pending/shadow bookkeeping; the shadow only moves
  // at a frame boundary (or scan start) so one frame never mixes two loads.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    upd_pending_d = upd_pending_q;
    frame_done_d  = 1'b0;
    apply_shadow  = 1'b0;

    if (!en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d      = ST_BLANK;
          idx_d        = '0;
          cnt_d        = '0;
          apply_shadow = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SCAN_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              apply_shadow = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    if (apply_shadow && upd_pending_q) begin
      shadow_d = pend_q;
    end

    if (load) begin
      pend_d        = value;
      upd_pending_d = 1'b1;
    end else if (apply_shadow) begin
      upd_pending_d = 1'b0;
    end
  end

  logic [NUM_DIG-1:0] lz_supp;
  logic               zero_run;

  // Output decode from next-state values: nibble select, leading-zero
  // suppression mask and the one-cold digit enable.
  always_comb begin
    enc_din_d  = 4'h0;
    dig_sel_d  = '1;
    lz_supp    = '0;
    zero_run   = 1'b1;

    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_d == IW'(i)) begin
        enc_din_d = shadow_d[4*i +: 4];
      end
    end

    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      zero_run   = zero_run & (shadow_d[4*i +: 4] == 4'h0);
      lz_supp[i] = zero_run;
    end

    if (state_d == ST_SHOW) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if ((idx_d == IW'(i)) && !(lz_en && lz_supp[i])) begin
          dig_sel_d[i] = 1'b0;
        end
      end
    end
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      idx_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      pend_q        <= '0;
      upd_pending_q <= 1'b0;
      enc_din_q     <= 4'h0;
      dig_sel_q     <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      upd_pending_q <= upd_pending_d;
      enc_din_q     <= enc_din_d;
      dig_sel_q     <= dig_sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign enc_din     = enc_din_q;
  assign dig_sel     = dig_sel_q;
  assign frame_done  = frame_done_q;
  assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: scoreboard bench for fnd_scan_ctrl. A time-based
// reference model pushes the expected outputs for every clock edge; a
// monitor on the falling edge pops and compares.
module tb_fnd_scan_ctrl;

  localparam int N     = 4;
  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * SCAN;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [4*N-1:0] value = '0;
  logic           load = 1'b0;
  logic           lz_en = 1'b0;
  logic [3:0]     enc_din;
  logic [N-1:0]   dig_sel;
  logic           frame_done;
  logic           upd_pending;

  fnd_scan_ctrl #(.NUM_DIG(N), .SCAN_DIV(SCAN), .BLANK_CYC(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .value       (value),
    .load        (load),
    .lz_en       (lz_en),
    .enc_din     (enc_din),
    .dig_sel     (dig_sel),
    .frame_done  (frame_done),
    .upd_pending (upd_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dig;
    logic [3:0]   enc;
    bit           enc_care;
    bit           fd;
    bit           upd;
  } exp_t;

  exp_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: time since scan start, shadow, pending value and flag.
  int           t_m     = -1;
  logic [4*N-1:0] shadow_m = '0;
  logic [4*N-1:0] pend_m   = '0;
  bit           flag_m  = 1'b0;

  task automatic check_output(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    t_m      = -1;
    shadow_m = '0;
    pend_m   = '0;
    flag_m   = 1'b0;
    exp_q.delete();
  endtask

  // Model step on each rising edge: derive expected outputs from elapsed time.
  always @(posedge clk) begin
    if (rst_n) begin
      exp_t e;
      bit apply_v;
      int digit;
      int pos;
      logic [4*N-1:0] sh;
      apply_v = 1'b0;
      e.fd = 1'b0;
      if (!en) begin
        t_m = -1;
      end else if (t_m < 0) begin
        t_m = 0;
        apply_v = 1'b1;
      end else begin
        t_m++;
        apply_v = ((t_m % FRAME) == 0);
        e.fd = apply_v;
      end
      if (apply_v && flag_m) shadow_m = pend_m;
      if (load) begin
        pend_m = value;
        flag_m = 1'b1;
      end else if (apply_v) begin
        flag_m = 1'b0;
      end
      e.upd = flag_m;
      if (t_m < 0) begin
        e.dig = '1;
        e.enc = 4'h0;
        e.enc_care = 1'b0;
      end else begin
        digit = (t_m / SCAN) % N;
        pos   = t_m % SCAN;
        sh    = shadow_m >> (4 * digit);
        e.enc = sh[3:0];
        e.enc_care = 1'b1;
        if (pos < BLANK || (lz_en && digit > 0 && sh == 0)) e.dig = '1;
        else e.dig = ~(N'(1) << digit);
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output("dig_sel", int'(dig_sel), int'(e.dig));
      check_output("frame_done", int'(frame_done), int'(e.fd));
      check_output("upd_pending", int'(upd_pending), int'(e.upd));
      if (e.enc_care) check_output("enc_din", int'(enc_din), int'(e.enc));
    end
  end

  task automatic apply_stimulus(input logic [4*N-1:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(t_m >= 0 && (t_m % FRAME) == p) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("[TB] FAIL wait_pos: position %0d not reached, t=%0d", p, t_m);
    end
  endtask

  initial begin
    model_reset();
    #7;
    check_output("reset dig_sel", int'(dig_sel), 4'hF);
    check_output("reset enc_din", int'(enc_din), 0);
    check_output("reset frame_done", int'(frame_done), 0);
    check_output("reset upd_pending", int'(upd_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(3);

    $display("[TB] scan of 1234 loaded while off");
    apply_stimulus(16'h1234);
    run_cycles(2);
    en = 1'b1;
    run_cycles(70);

    $display("[TB] mid-frame load of ABCD");
    wait_pos(9);
    apply_stimulus(16'hABCD);
    run_cycles(60);

    $display("[TB] leading-zero suppression");
    lz_en = 1'b1;
    apply_stimulus(16'h0050);
    run_cycles(70);
    apply_stimulus(16'h0000);
    run_cycles(70);
    lz_en = 1'b0;

    $display("[TB] last load wins, boundary load deferred");
    wait_pos(5);
    apply_stimulus(16'h1111);
    wait_pos(15);
    apply_stimulus(16'h2222);
    wait_pos(31);
    apply_stimulus(16'h3333);
    run_cycles(70);

    $display("[TB] disable during digit 2 show");
    wait_pos(2 * SCAN + 3);
    en = 1'b0;
    run_cycles(5);
    en = 1'b1;
    run_cycles(40);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom());
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 39) == 0) en = ~en;
      @(negedge clk);
    end
    load  = 1'b0;
    en    = 1'b1;
    lz_en = 1'b0;
    run_cycles(3);

    $display("[TB] async reset mid-show");
    apply_stimulus(16'h9876);
    run_cycles(2 * FRAME);
    wait_pos(12);
    apply_stimulus(16'h5555);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async dig_sel", int'(dig_sel), 4'hF);
    check_output("async enc_din", int'(enc_din), 0);
    check_output("async upd_pending", int'(upd_pending), 0);
    check_output("async frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(40);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
